// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample word and loader state encoding for the 64-point FFT
package fft_pkg;
    localparam int N_POINTS = 64;
    localparam int LOG2_N = 6;
    localparam int DATA_W = 16;
    typedef logic [DATA_W-1:0] sample_t;
    typedef enum logic [1:0] {FILL, START, BUSY} state_t;
endpackage

// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if: sample stream, core handshake and frame buffer of the FFT input stage
interface fft_frame_loader_if;
    import fft_pkg::*;
    logic in_valid;
    logic in_ready;
    logic in_sof;
    sample_t in_re;
    sample_t in_im;
    logic fft_done;
    logic fft_start;
    logic busy;
    logic sof_err;
    logic [7:0] frames_loaded;
    sample_t frame_re [N_POINTS];
    sample_t frame_im [N_POINTS];
    modport master (
        output in_valid, in_sof, in_re, in_im, fft_done,
        input in_ready, fft_start, busy, sof_err, frames_loaded, frame_re, frame_im
    );
    modport slave (
        input in_valid, in_sof, in_re, in_im, fft_done,
        output in_ready, fft_start, busy, sof_err, frames_loaded, frame_re, frame_im
    );
endinterface

// File: rtl/fft_bit_reverse.sv
// fft_bit_reverse: combinational reversal of a LOG2_N-bit sample index
module fft_bit_reverse #(
    parameter int LOG2_N = 6
) (
    input  logic [LOG2_N-1:0] idx,
    output logic [LOG2_N-1:0] rev
);
    for (genvar g = 0; g < LOG2_N; g++) begin : g_bit
        assign rev[g] = idx[LOG2_N-1-g];
    end
endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: gathers one frame of streamed samples, permuted, and hands it to the FFT core
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter bit BIT_REVERSE = 1
) (
    input logic clk,
    input logic rst,
    fft_frame_loader_if.slave io
);
    state_t state, state_nx;
    logic [LOG2_N-1:0] idx, cur, rev, addr;
    logic accept, last;

    fft_bit_reverse #(.LOG2_N(LOG2_N)) u_rev (.idx(cur), .rev(rev));

    assign io.in_ready = state == FILL;
    assign io.fft_start = state == START;
    assign io.busy = state == BUSY;

    // A first-of-frame sample always lands at index 0, restarting the frame
    always_comb begin
        accept = io.in_valid & io.in_ready;
        cur = io.in_sof ? '0 : idx;
        addr = BIT_REVERSE ? rev : cur;
        last = accept & (&cur);
        state_nx = last ? START : state == START ? BUSY : (state == BUSY && io.fft_done) ? FILL : state;
    end

    // State, sample index and status counters
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
            idx <= '0;
            io.sof_err <= 1'b0;
            io.frames_loaded <= '0;
        end else begin
            state <= state_nx;
            if (accept) idx <= cur + 1'b1;
            if (accept && io.in_sof && idx != '0) io.sof_err <= 1'b1;
            if (last) io.frames_loaded <= io.frames_loaded + 8'd1;
        end
    end

    // Frame buffer: written only on accepted samples, frozen otherwise
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_POINTS; i++) begin
                io.frame_re[i] <= '0;
                io.frame_im[i] <= '0;
            end
        end else if (accept) begin
            io.frame_re[addr] <= io.in_re;
            io.frame_im[addr] <= io.in_im;
        end
    end
endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
Upstream input stage of the 64-point FFT. It accepts a stream of complex samples on a valid/ready handshake and assembles one full frame in a register buffer, stored in bit-reversed order. It then pulses start to the butterfly core and holds the frame stable until the core reports done. This gives the core a parallel, pre-permuted frame and frees it from stream timing.

Parameters:
N_POINTS, 64, frame length in samples (power of 2)
LOG2_N, 6, log2(N_POINTS); width of sample index
DATA_W, 16, width of each real/imag component
BIT_REVERSE, 1, 1 = store sample k at bitrev(k); 0 = store at k

Ports:
clk  input  1  clock; all flops update on falling edge
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  sample present on in_re/in_im
in_ready  output  1  loader can accept a sample this cycle
in_re  input  DATA_W  sample real part
in_im  input  DATA_W  sample imaginary part
in_sof  input  1  qualifies the accepted sample as first of a frame
fft_done  input  1  core finished with current frame (1-cycle pulse)
fft_start  output  1  1-cycle pulse: frame buffer valid, core may load
frame_re  output  N_POINTS x DATA_W  frame buffer real parts (unpacked array)
frame_im  output  N_POINTS x DATA_W  frame buffer imaginary parts
busy  output  1  frame handed to core, awaiting fft_done
sof_err  output  1  sticky: frame restarted by mid-frame in_sof
frames_loaded  output  8  count of frames handed to core, wraps 255->0

Behaviour:
- Reset (rst=0, any time, including mid-frame or mid-BUSY): state=FILL, index=0, all frame_re/frame_im=0, fft_start=0, busy=0, sof_err=0, frames_loaded=0. Outputs change immediately (async).
- Accept = in_valid & in_ready, sampled at the falling edge.
- States: FILL, START, BUSY.
- FILL:
  - in_ready=1.
  - On accept, write in_re/in_im to address a. a = bitrev(index) if BIT_REVERSE, else index. index increments.
  - Accept with in_sof=1 and index!=0: sample is written to address 0, index becomes 1, sof_err set (sticky until reset). Previously written entries are not cleared.
  - Accept with in_sof=1 and index=0: normal.
  - Accept with in_sof=0 and index=0: allowed; a frame need not start with sof.
  - Accept when index==N_POINTS-1: write, index wraps to 0, go to START.
- START (exactly one cycle):
  - fft_start=1, in_ready=0, frames_loaded increments.
  - Next state BUSY.
- BUSY:
  - busy=1, in_ready=0, frame buffer frozen.
  - fft_done=1 moves to FILL on that edge. in_ready=1 in the following cycle.
- fft_done in FILL or START is ignored. It does not queue.
- Latency: last sample accepted at edge E. fft_start is high for the cycle between E and E+1, and busy rises at E+1.
- Minimum frame period: N_POINTS accept cycles + 1 START cycle + BUSY duration.
- in_valid=0 gaps during FILL hold index. There is no timeout.
- Frame buffer is written only in FILL. Entries not yet overwritten in a new frame keep prior-frame values.
- Buffer contents in START/BUSY are bit-exact copies of accepted samples. No arithmetic, no saturation.
- in_ready is a registered-state decode only. It has no combinational path from in_valid.

Decomposition:
- Shared package fft_pkg holds:
  - constants N_POINTS=64, LOG2_N=6, DATA_W=16
  - the loader state enum {FILL, START, BUSY}
  - a typedef for the DATA_W sample word
- One sub-module, fft_bit_reverse: a combinational LOG2_N-bit index reversal, parameterised by LOG2_N. The FFT core's reordering logic reuses it.

Test Plan:
- Reset then stream samples k=0..63 with re=k, im=-k, in_valid=1 every cycle -> in_ready high for 64 accepts. One-cycle fft_start follows. frame_re[1]=32, frame_re[32]=1, frame_re[63]=63, frame_im[6]=-24 (bitrev(24)=6). frames_loaded=1. BUSY is held.
- In BUSY, drive in_valid=1 for 20 cycles, then pulse fft_done -> in_ready=0 throughout and buffer unchanged. FILL is re-entered and in_ready=1 the next cycle.
- Stream 10 samples, assert in_sof on the 11th (re=0x7FFF), then 63 more -> sof_err=1. frame_re[0]=0x7FFF. fft_start fires after 64 accepts counted from the sof sample.
- BIT_REVERSE=0, ramp re=k with random in_valid gaps (~50%) -> frame_re[k]=k for all k. fft_start occurs exactly once.
- Assert rst=0 asynchronously after 40 accepted samples, and again during BUSY -> outputs zero immediately. After release the next frame requires a full 64 samples.
- Load 256 frames with an immediate fft_done each -> frames_loaded wraps to 0. Exactly 256 fft_start pulses are observed.
